// File: rtl/rr_arb_mux.sv
// ============================================================================
// Module   : rr_arb_mux
// Desc     : N-input valid/ready selector, fixed-select or round-robin, with a
//            registered output stage. Optional packet lock: RR_MUX_LAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
`ifdef RR_MUX_LAST_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return s[SEL_W-1:0];
    endfunction

    logic             ptr_unused_guard;
    logic [SEL_W-1:0] ptr;
    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    logic             sel_ok;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             can_load;
    logic             xfer;

`ifdef RR_MUX_LAST_EN
    logic             lock;
    logic [SEL_W-1:0] lock_ch;
`endif

    assign ptr_unused_guard = 1'b0;
    // Held in reset: no channel may see a ready.
    assign can_load = reset_n && (!out_valid || out_ready);
    assign sel_ok   = ({1'b0, sel} < (SEL_W+1)'(N));

    // Reverse scan so the candidate nearest to ptr is the last one written.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (in_valid[wrap_add(ptr, k)]) begin
                rr_found = 1'b1;
                rr_idx   = wrap_add(ptr, k);
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
`ifdef RR_MUX_LAST_EN
        if (lock) begin
            grant_vld = in_valid[lock_ch];
            grant_idx = lock_ch;
        end else
`endif
        if (mode) begin
            grant_vld = rr_found;
            grant_idx = rr_idx;
        end else if (sel_ok && in_valid[sel]) begin
            grant_vld = 1'b1;
            grant_idx = sel;
        end
    end

    assign xfer = grant_vld && can_load && !ptr_unused_guard;

    always_comb begin
        in_ready = '0;
        if (grant_vld && can_load) in_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef RR_MUX_LAST_EN
            out_last  <= 1'b0;
            lock      <= 1'b0;
            lock_ch   <= '0;
`endif
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_sel   <= grant_idx;
                if (mode) ptr <= wrap_add(grant_idx, 1);
`ifdef RR_MUX_LAST_EN
                out_last <= in_last[grant_idx];
                lock     <= !in_last[grant_idx];
                lock_ch  <= grant_idx;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// ============================================================================
// Module   : tb_rr_arb_mux
// Desc     : Directed, table-driven self-checking bench for rr_arb_mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb_mux;
    localparam int N     = 8;
    localparam int WIDTH = 32;
    localparam int SEL_W = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;
`ifdef RR_MUX_LAST_EN
    logic [N-1:0]       in_last;
    logic               out_last;
`endif

    int tests = 0;
    int fails = 0;

    rr_arb_mux #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef RR_MUX_LAST_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] chdat(input int i);
        return {16'hA5A5, 16'(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             mode;
        logic [SEL_W-1:0] sel;
        logic [N-1:0]     vld;
        logic             ordy;
        logic [N-1:0]     exp_rdy;
        logic             exp_ov;
        logic [SEL_W-1:0] exp_os;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Sequential rows starting from reset (ptr=0, out_valid=0).
        vecs[0]  = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5};
        vecs[1]  = '{1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd5};
        vecs[2]  = '{1'b0, 3'd2, 8'hFB, 1'b1, 8'h00, 1'b0, 3'd5};
        vecs[3]  = '{1'b0, 3'd2, 8'h04, 1'b0, 8'h04, 1'b1, 3'd2};
        vecs[4]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h04, 1'b1, 3'd2};
        vecs[5]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h40, 1'b1, 3'd6};
        vecs[6]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h04, 1'b1, 3'd2};
        vecs[7]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h40, 1'b1, 3'd6};
        vecs[8]  = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd6};
        vecs[9]  = '{1'b1, 3'd0, 8'h01, 1'b1, 8'h01, 1'b1, 3'd0};
        vecs[10] = '{1'b1, 3'd0, 8'h80, 1'b0, 8'h00, 1'b1, 3'd0};
        vecs[11] = '{1'b0, 3'd7, 8'h80, 1'b1, 8'h80, 1'b1, 3'd7};
        vecs[12] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1};

        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = chdat(i);
`ifdef RR_MUX_LAST_EN
        in_last = '1;
`endif

        // Reset held with every channel valid.
        reset_n   = 1'b0;
        in_valid  = '1;
        mode      = 1'b1;
        sel       = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_sel",   64'(out_sel),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);

        @(negedge clk);
        reset_n = 1'b1;
        #1 check("rel_in_ready", 64'(in_ready), 64'h01);

        // Round-robin over all valid channels, one beat per cycle.
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("rr_ov[%0d]", k),  64'(out_valid), 64'd1);
            check($sformatf("rr_sel[%0d]", k), 64'(out_sel),   64'(k % N));
            check($sformatf("rr_dat[%0d]", k), 64'(out_data),  64'(chdat(k % N)));
        end

        // Back-pressure: output holds channel 1, ptr now 2.
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("bp_rdy[%0d]", k), 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            check($sformatf("bp_ov[%0d]", k),  64'(out_valid), 64'd1);
            check($sformatf("bp_dat[%0d]", k), 64'(out_data),  64'(chdat(1)));
            check($sformatf("bp_sel[%0d]", k), 64'(out_sel),   64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("bp_release_rdy", 64'(in_ready), 64'h04);
        @(posedge clk); #1;
        check("bp_release_ov",  64'(out_valid), 64'd1);
        check("bp_release_sel", 64'(out_sel),   64'd2);
        check("bp_release_dat", 64'(out_data),  64'(chdat(2)));

        // Asynchronous reset between edges with data held.
        @(negedge clk);
        in_valid = '0;
        reset_n  = 1'b0;
        #1;
        check("async_rst_ov",  64'(out_valid), 64'd0);
        check("async_rst_dat", 64'(out_data),  64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[r]) begin
            @(negedge clk);
            mode      = vecs[r].mode;
            sel       = vecs[r].sel;
            in_valid  = vecs[r].vld;
            out_ready = vecs[r].ordy;
            #1 check($sformatf("vec%0d_in_ready", r), 64'(in_ready), 64'(vecs[r].exp_rdy));
            @(posedge clk); #1;
            check($sformatf("vec%0d_out_valid", r), 64'(out_valid), 64'(vecs[r].exp_ov));
            check($sformatf("vec%0d_out_sel", r),   64'(out_sel),   64'(vecs[r].exp_os));
            check($sformatf("vec%0d_out_data", r),  64'(out_data),  64'(chdat(int'(vecs[r].exp_os))));
        end

`ifdef RR_MUX_LAST_EN
        // Channel 1 sends a 3-beat packet while channel 4 waits.
        @(negedge clk);
        in_valid = '0;
        reset_n  = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        mode      = 1'b1;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            in_valid = (b < 3) ? 8'h12 : 8'h10;
            in_last  = (b < 2) ? 8'h00 : 8'h12;
            #1 check($sformatf("lock_rdy[%0d]", b), 64'(in_ready), (b < 3) ? 64'h02 : 64'h10);
            @(posedge clk); #1;
            check($sformatf("lock_sel[%0d]", b),  64'(out_sel),  (b < 3) ? 64'd1 : 64'd4);
            check($sformatf("lock_last[%0d]", b), 64'(out_last), (b < 2) ? 64'd0 : 64'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
